// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage of the core. Owns the program counter, issues word fetches
//   to instruction memory over a req/ack handshake with variable latency,
//   and hands each fetched word to decode over a valid/ready handshake.
//   Branch/jump redirects and the ECALL halt are applied here.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   imem_req        fetch request, held until imem_ack
//   imem_addr       word-aligned fetch address
//   imem_ack        imem_rdata valid this cycle; ends the request
//   imem_rdata      fetched instruction word
//   inst_valid      inst/inst_pc hold an instruction for decode
//   inst_ready      decode accepts inst this cycle
//   inst            instruction to decode
//   inst_pc         PC of inst
//   redirect_valid  taken branch/JAL/JALR, fetch from redirect_pc
//   redirect_pc     redirect target, bits [1:0] ignored
//   halt            ECALL halt request
//   is_halted       fetch stopped until reset
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        is_halted
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    VALID  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] redir_pc, redir_pc_nx;
  logic        redir_pend, redir_pend_nx;
  logic        halt_pend, halt_pend_nx;
  logic        req_gap, req_gap_nx;
  logic        load_inst;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Sequential successor; 32-bit unsigned, wraps past 32'hFFFF_FFFC.
  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    redir_pc_nx   = redir_pc;
    redir_pend_nx = redir_pend;
    halt_pend_nx  = halt_pend;
    req_gap_nx    = 1'b0;
    load_inst     = 1'b0;

    case (state)
      IDLE: begin
        if (halt) begin
          state_nx = HALTED;
        end else begin
          state_nx = FETCH;
          if (redirect_valid) pc_nx = word_align(redirect_pc);
        end
      end

      FETCH: begin
        if (req_gap) begin
          // Dead cycle after a dropped fetch: no request is outstanding,
          // so events can be applied directly.
          if (halt || halt_pend) begin
            state_nx     = HALTED;
            halt_pend_nx = 1'b0;
          end else if (redirect_valid) begin
            pc_nx = word_align(redirect_pc);
          end
        end else if (imem_ack) begin
          if (halt || halt_pend) begin
            state_nx      = HALTED;
            halt_pend_nx  = 1'b0;
            redir_pend_nx = 1'b0;
          end else if (redirect_valid) begin
            // A live redirect is newer than anything latched earlier.
            pc_nx         = word_align(redirect_pc);
            redir_pend_nx = 1'b0;
            req_gap_nx    = 1'b1;
          end else if (redir_pend) begin
            pc_nx         = redir_pc;
            redir_pend_nx = 1'b0;
            req_gap_nx    = 1'b1;
          end else begin
            load_inst = 1'b1;
            state_nx  = VALID;
          end
        end else begin
          // The request is never abandoned; remember events until the ack.
          if (halt) halt_pend_nx = 1'b1;
          if (redirect_valid) begin
            redir_pend_nx = 1'b1;
            redir_pc_nx   = word_align(redirect_pc);
          end
        end
      end

      VALID: begin
        if (halt) begin
          state_nx = HALTED;
        end else if (redirect_valid) begin
          pc_nx    = word_align(redirect_pc);
          state_nx = FETCH;
        end else if (inst_ready) begin
          pc_nx    = pc_inc(inst_pc);
          state_nx = FETCH;
        end
      end

      HALTED: begin
        state_nx = HALTED;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC_ALIGNED;
      redir_pc   <= RESET_PC_ALIGNED;
      redir_pend <= 1'b0;
      halt_pend  <= 1'b0;
      req_gap    <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      redir_pc   <= redir_pc_nx;
      redir_pend <= redir_pend_nx;
      halt_pend  <= halt_pend_nx;
      req_gap    <= req_gap_nx;
      if (load_inst) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
    end
  end

  // pc only moves on ack, redirect-in-gap or accept, so the address is
  // stable for the whole life of a request.
  assign imem_req   = (state == FETCH) && !req_gap;
  assign imem_addr  = pc;
  assign inst_valid = (state == VALID);
  assign is_halted  = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        is_halted;

  int n_chk;
  int n_pass;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .is_halted      (is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},    {31'd0, imem_req},   32'd0);
    chk({tag, ".addr"},   imem_addr,           32'd0);
    chk({tag, ".valid"},  {31'd0, inst_valid}, 32'd0);
    chk({tag, ".inst"},   inst,                32'd0);
    chk({tag, ".pc"},     inst_pc,             32'd0);
    chk({tag, ".halted"}, {31'd0, is_halted},  32'd0);
  endtask

  // Present ack with data in the current cycle.
  task automatic ack_now(input logic [31:0] d);
    imem_ack   = 1'b1;
    imem_rdata = d;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    halt = 1'b0;
    #2;
    chk_reset_vals("rst0");
    step();
    step();
    reset = 1'b1;

    // 1: first fetch, ack two cycles after request
    step();
    chk("t1.req", {31'd0, imem_req}, 32'd1);
    chk("t1.addr", imem_addr, 32'h0);
    step();
    step();
    chk("t1.req_hold", {31'd0, imem_req}, 32'd1);
    chk("t1.addr_hold", imem_addr, 32'h0);
    ack_now(32'h00A0_0093);
    chk("t1.valid", {31'd0, inst_valid}, 32'd1);
    chk("t1.inst", inst, 32'h00A0_0093);
    chk("t1.ipc", inst_pc, 32'h0);
    chk("t1.req_off", {31'd0, imem_req}, 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t1.next_addr", imem_addr, 32'h4);
    chk("t1.next_req", {31'd0, imem_req}, 32'd1);
    chk("t1.valid_off", {31'd0, inst_valid}, 32'd0);

    // 2: zero-wait ack, then backpressure for 3 cycles
    ack_now(32'h0020_0113);
    for (int i = 0; i < 3; i++) begin
      chk("t2.valid", {31'd0, inst_valid}, 32'd1);
      chk("t2.inst", inst, 32'h0020_0113);
      chk("t2.ipc", inst_pc, 32'h4);
      chk("t2.req", {31'd0, imem_req}, 32'd0);
      step();
    end
    chk("t2.valid4", {31'd0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t2.next_addr", imem_addr, 32'h8);
    chk("t2.next_req", {31'd0, imem_req}, 32'd1);

    // 4: redirect to 0x203 during FETCH@0x8, ack three cycles later
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    for (int i = 0; i < 2; i++) begin
      chk("t4.addr_hold", imem_addr, 32'h8);
      chk("t4.req_hold", {31'd0, imem_req}, 32'd1);
      step();
    end
    chk("t4.addr_hold3", imem_addr, 32'h8);
    ack_now(32'hDEAD_BEEF);
    chk("t4.gap_req", {31'd0, imem_req}, 32'd0);
    chk("t4.dropped", {31'd0, inst_valid}, 32'd0);
    step();
    chk("t4.new_req", {31'd0, imem_req}, 32'd1);
    chk("t4.new_addr", imem_addr, 32'h200);

    // 3: redirect to 0x100 while VALID and not ready
    ack_now(32'h0000_0013);
    chk("t3.valid", {31'd0, inst_valid}, 32'd1);
    chk("t3.ipc", inst_pc, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    chk("t3.valid_off", {31'd0, inst_valid}, 32'd0);
    chk("t3.addr", imem_addr, 32'h100);
    chk("t3.req", {31'd0, imem_req}, 32'd1);

    // 6: redirect to 0xFFFF_FFFC, accept, address wraps to 0
    ack_now(32'h0010_0093);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("t6.addr_top", imem_addr, 32'hFFFF_FFFC);
    ack_now(32'h0030_0193);
    chk("t6.ipc_top", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t6.wrap", imem_addr, 32'h0);
    chk("t6.wrap_req", {31'd0, imem_req}, 32'd1);
    ack_now(32'h0040_0213);
    chk("t6.ipc0", inst_pc, 32'h0);
    halt = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    step();
    halt = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("t6.halted", {31'd0, is_halted}, 32'd1);
    chk("t6.valid", {31'd0, inst_valid}, 32'd0);
    chk("t6.req", {31'd0, imem_req}, 32'd0);
    step();
    step();
    chk("t6.sticky", {31'd0, is_halted}, 32'd1);

    // Reset mid-cycle while halted: outputs return at once
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_halt");
    step();
    reset = 1'b1;

    // 5: halt during FETCH, ack two cycles later
    step();
    chk("t5.req", {31'd0, imem_req}, 32'd1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("t5.req_kept", {31'd0, imem_req}, 32'd1);
    chk("t5.not_yet", {31'd0, is_halted}, 32'd0);
    step();
    ack_now(32'h0050_0293);
    chk("t5.halted", {31'd0, is_halted}, 32'd1);
    chk("t5.no_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t5.req_off", {31'd0, imem_req}, 32'd0);
      step();
    end

    // Reset mid-VALID, with an ack arriving around reset release
    #3;
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
    step();
    ack_now(32'h0060_0313);
    chk("rv.valid", {31'd0, inst_valid}, 32'd1);
    chk("rv.inst", inst, 32'h0060_0313);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_valid");
    imem_ack = 1'b1;
    imem_rdata = 32'h0070_0393;
    step();
    reset = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    chk("rv.stale_ack", {31'd0, inst_valid}, 32'd0);
    chk("rv.refetch", {31'd0, imem_req}, 32'd1);
    chk("rv.refetch_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
